r2sdf_seq_ctrl: RTL and testbench
=================================

# r2sdf_seq_ctrl

Central sequencer for the radix-2 single-delay-feedback FFT pipeline. It accepts a framed input sample stream and generates, for all N butterfly stages, a common advance enable, the per-stage shift/butterfly select and twiddle ROM addresses. It also produces framed output valid/SOF/EOF after the pipeline latency and drains the last frame with zero injection. It sits between the sample source and the chain of N stages; stages hold no control counters of their own.

## Interface
- N, 3, log2 FFT size; stages n = 1..N.
- STAGE_REG, 1, output register cycles per stage (0 or 1).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample present.
- in_sof  in  1  first sample of a frame; qualified by in_valid.
- in_ready  out  1  controller accepts a sample this cycle.
- flush  in  1  request to drain the pipeline; single-cycle pulse, latched.
- en  out  1  advance enable shared by all stages.
- zero_in  out  1  stage 1 must consume 0+0j instead of the input sample.
- sel  out  N  bit n-1: 1 = butterfly, 0 = shift, for stage n.
- tw_addr  out  N*(N-1)  field n-1, N-1 bits wide: cos/sin ROM index for stage n.
- out_valid  out  1  stage N output is a valid FFT sample.
- out_sof / out_eof  out  1 each  first/last output sample of a frame.
- frame_cnt  out  16  completed output frames, wraps.
- err  out  1  one-cycle pulse on in_sof at a non-zero frame index.

## Operation
- Constants, per advance rather than per cycle: D_1 = 0; D_n = D_(n-1) + 2^(N-n+1) + STAGE_REG; LAT = 2^N - 1 + N*STAGE_REG.
- States:
  - IDLE → RUN when in_valid and in_sof are both high; that sample is index 0.
  - In IDLE, a sample without in_sof is consumed and ignored.
  - In RUN, flush is latched into pend.
  - RUN → FLUSH when pend is set and the advance counter is 0 (frame boundary).
  - FLUSH → IDLE after exactly LAT advances.
- Handshake:
  - in_ready = 1 in IDLE and RUN; 0 in FLUSH and during rst.
  - en = in_valid & in_ready & (RUN | in_sof), or 1 throughout FLUSH.
  - zero_in = 1 only in FLUSH.
- Counters:
  - adv: N-bit advance counter, +1 per en, wraps 2^N.
  - fill: saturates at LAT, +1 per en; cleared on IDLE→RUN.
  - oidx: N-bit output index, +1 per out_valid.
- Stage decode: c_n = (adv - D_n) mod 2^N.
  - sel[n-1] = bit (N-n) of c_n.
  - tw_addr_n = (c_n mod 2^(N-n)) << (n-1).
  - For stage N, tw_addr is always 0.
- Output framing:
  - out_valid = en & (fill == LAT), using the pre-increment value of fill.
  - out_sof = out_valid & (oidx == 0); out_eof = out_valid & (oidx == 2^N-1).
  - frame_cnt increments on out_eof.
- Boundaries:
  - in_sof in RUN with adv ≠ 0: pulse err; force adv := 0 so this sample becomes index 0; clear fill and oidx. Outputs stay suppressed until refill. pend is preserved.
  - flush in IDLE is ignored.
  - flush in FLUSH is ignored.
  - flush in RUN at adv == 0 enters FLUSH on the next cycle.
  - rst mid-frame or mid-flush: everything is cleared, pend is cleared, the state returns to IDLE.

## Timing
- Reset values: state IDLE, adv/fill/oidx/frame_cnt/pend = 0; all outputs 0. in_ready is 0 during rst and 1 in the first cycle after it.
- Combinational from registered state: in_ready, en, zero_in, sel, tw_addr, out_*.
  - These outputs are valid in the same cycle as the en they qualify.
  - Stages sample on the clk edge where en = 1.
- Latency is LAT advances, input to output; it is LAT cycles only under continuous in_valid.
- Stalls: in_valid low in RUN gives en = 0; all counters hold and the decodes hold their values.
- err, out_sof and out_eof are single-cycle pulses, each coincident with its en.

## Structure
- Shared package r2sdf_pkg holds:
  - typedef fpt (32-bit signed Q16.16);
  - typedef cpx (fpt[1:0], [1] = real);
  - function r2sdf_lat(N, STAGE_REG);
  - function r2sdf_dly(N, n, STAGE_REG).
- One sub-module, r2sdf_stage_dec (parameters N, n, STAGE_REG): maps adv to sel bit and tw_addr. It is instantiated N times by a generate loop.

## Test plan
All scenarios use N = 3 and STAGE_REG = 1, giving D = {0, 5, 8} and LAT = 10.
- Reset and first frame:
  - Stimulus: rst, then continuous in_valid, in_sof at sample 0.
  - Response: sel[0] is 0,0,0,0,1,1,1,1 over adv 0..7; tw_addr stage 1 is 0,1,2,3 repeating; stage 2 is 0,2 repeating; stage 3 is 0.
- Latency:
  - Stimulus: two back-to-back frames.
  - Response: first out_valid at the 11th en cycle with out_sof; out_eof 7 advances later; frame_cnt = 1, then 2.
- Stalls:
  - Stimulus: in_valid low for 3 cycles at sample 5.
  - Response: en = 0 and sel/tw_addr are frozen; output timing shifts by exactly 3 cycles.
- Flush:
  - Stimulus: flush pulse at sample 3 of frame 2.
  - Response: FLUSH is entered at the frame boundary; in_ready = 0, zero_in = 1, en = 1 for 10 cycles; the last out_eof appears on the final flush cycle; the state returns to IDLE.
- Resync:
  - Stimulus: in_sof at adv = 5.
  - Response: err pulses once; out_valid = 0 for the next 10 advances; then out_sof.
- Reset mid-flush:
  - Stimulus: rst at flush cycle 4.
  - Response: all outputs are 0 and frame_cnt = 0; in_ready = 1 in the next cycle.

Source files
------------

// File: rtl/r2sdf_pkg.sv
// Shared types and constant helpers for the radix-2 SDF FFT pipeline.
// Pipeline delays and latency are counted in advances (en cycles), not clock cycles.
package r2sdf_pkg;

    typedef logic signed [31:0] fpt;
    typedef fpt [1:0] cpx;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } seq_state_e;

    function automatic int r2sdf_lat(input int n_log, input int stage_reg);
        return (32'sd1 << n_log) - 32'sd1 + n_log * stage_reg;
    endfunction

    // Accumulated advance offset of stage 'stage' relative to stage 1.
    function automatic int r2sdf_dly(input int n_log, input int stage, input int stage_reg);
        int d;
        d = 32'sd0;
        for (int k = 2; k <= stage; k++) begin
            d += (32'sd1 << (n_log - k + 1)) + stage_reg;
        end
        return d;
    endfunction

endpackage

// File: rtl/r2sdf_stage_dec.sv
// Per-stage decode of the shared advance counter into shift/butterfly select
// and twiddle ROM index, offset by the stage's accumulated pipeline delay.
module r2sdf_stage_dec
    import r2sdf_pkg::*;
#(
    parameter int N         = 3,
    parameter int n         = 1,
    parameter int STAGE_REG = 1
) (
    input  logic [N-1:0] adv,
    output logic         sel,
    output logic [N-2:0] tw_addr
);

    localparam int           D       = r2sdf_dly(N, n, STAGE_REG);
    localparam logic [N-1:0] D_MOD   = N'(D % (32'sd1 << N));
    localparam logic [N-1:0] TW_MASK = N'((32'sd1 << (N - n)) - 32'sd1);

    logic [N-1:0] c;

    // Local frame index of this stage and the decodes derived from it.
    always_comb begin
        c       = adv - D_MOD;
        sel     = c[N-n];
        tw_addr = (N-1)'((c & TW_MASK) << (n - 1));
    end

endmodule

// File: rtl/r2sdf_seq_ctrl.sv
// Central sequencer for the radix-2 SDF FFT: advance enable, per-stage decode,
// output framing and zero-injected drain of the final frame.
module r2sdf_seq_ctrl
    import r2sdf_pkg::*;
#(
    parameter int N         = 3,
    parameter int STAGE_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_sof,
    output logic                 in_ready,
    input  logic                 flush,
    output logic                 en,
    output logic                 zero_in,
    output logic [N-1:0]         sel,
    output logic [N*(N-1)-1:0]   tw_addr,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic [15:0]          frame_cnt,
    output logic                 err
);

    localparam int             LAT      = r2sdf_lat(N, STAGE_REG);
    localparam int             FW       = $clog2(LAT + 1);
    localparam logic [FW-1:0]  LAT_F    = FW'(LAT);
    localparam logic [FW-1:0]  FILL_ONE = FW'(32'd1);
    localparam logic [N-1:0]   ADV_ONE  = N'(32'd1);
    localparam logic [N-1:0]   ADV_ZERO = {N{1'b0}};
    localparam logic [N-1:0]   ADV_LAST = {N{1'b1}};

    seq_state_e     state_q, state_d;
    logic [N-1:0]   adv_q, adv_d, adv_eff;
    logic [N-1:0]   oidx_q, oidx_d, oidx_eff;
    logic [FW-1:0]  fill_q, fill_d, fill_eff;
    logic [FW-1:0]  fcnt_q, fcnt_d;
    logic           pend_q, pend_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic           restart;
    logic           pend_eff;

    // Handshake, frame (re)start detection and counter/state next values.
    always_comb begin
        in_ready = 1'b0;
        en       = 1'b0;
        zero_in  = 1'b0;
        err      = 1'b0;
        restart  = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    in_ready = 1'b1;
                    en       = in_valid & in_sof;
                    restart  = in_valid & in_sof;
                end
                ST_RUN: begin
                    in_ready = 1'b1;
                    en       = in_valid;
                    err      = in_valid & in_sof & (adv_q != ADV_ZERO);
                    restart  = in_valid & in_sof & (adv_q != ADV_ZERO);
                end
                ST_FLUSH: begin
                    en      = 1'b1;
                    zero_in = 1'b1;
                end
                default: begin
                    in_ready = 1'b0;
                end
            endcase
        end else begin
            in_ready = 1'b0;
        end

        // A (re)starting sample is index 0 with an empty pipeline, in this same cycle.
        adv_eff  = restart ? ADV_ZERO : adv_q;
        oidx_eff = restart ? ADV_ZERO : oidx_q;
        fill_eff = restart ? {FW{1'b0}} : fill_q;

        out_valid = en & (fill_eff == LAT_F);
        out_sof   = out_valid & (oidx_eff == ADV_ZERO);
        out_eof   = out_valid & (oidx_eff == ADV_LAST);

        adv_d       = en ? adv_eff + ADV_ONE : adv_eff;
        fill_d      = (en && (fill_eff != LAT_F)) ? fill_eff + FILL_ONE : fill_eff;
        oidx_d      = out_valid ? oidx_eff + ADV_ONE : oidx_eff;
        frame_cnt_d = out_eof ? frame_cnt_q + 16'd1 : frame_cnt_q;

        state_d  = state_q;
        pend_d   = pend_q;
        fcnt_d   = fcnt_q;
        pend_eff = pend_q | flush;
        case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                fcnt_d = {FW{1'b0}};
                if (restart) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Drain only once the current frame is complete (counter back at 0).
                if (pend_eff && (adv_d == ADV_ZERO)) begin
                    state_d = ST_FLUSH;
                    pend_d  = 1'b0;
                    fcnt_d  = {FW{1'b0}};
                end else begin
                    state_d = ST_RUN;
                    pend_d  = pend_eff;
                end
            end
            ST_FLUSH: begin
                pend_d = 1'b0;
                if (fcnt_q == LAT_F - FILL_ONE) begin
                    state_d = ST_IDLE;
                    fcnt_d  = {FW{1'b0}};
                end else begin
                    state_d = ST_FLUSH;
                    fcnt_d  = fcnt_q + FILL_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
                fcnt_d  = {FW{1'b0}};
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            adv_q       <= ADV_ZERO;
            oidx_q      <= ADV_ZERO;
            fill_q      <= {FW{1'b0}};
            fcnt_q      <= {FW{1'b0}};
            pend_q      <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            adv_q       <= adv_d;
            oidx_q      <= oidx_d;
            fill_q      <= fill_d;
            fcnt_q      <= fcnt_d;
            pend_q      <= pend_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;

    for (genvar g = 1; g <= N; g++) begin : g_stage
        r2sdf_stage_dec #(
            .N         (N),
            .n         (g),
            .STAGE_REG (STAGE_REG)
        ) u_dec (
            .adv     (adv_eff),
            .sel     (sel[g-1]),
            .tw_addr (tw_addr[(g-1)*(N-1) +: (N-1)])
        );
    end

endmodule

// File: tb/tb_r2sdf_seq_ctrl.sv
// Directed bench for r2sdf_seq_ctrl with N = 3, STAGE_REG = 1 (D = {0,5,8}, LAT = 10).
module tb_r2sdf_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        flush = 1'b0;
    logic        in_ready, en, zero_in, out_valid, out_sof, out_eof, err;
    logic [2:0]  sel;
    logic [5:0]  tw_addr;
    logic [15:0] frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Hand-derived decode per frame index: sel = {s3,s2,s1}, tw_addr = {tw3,tw2,tw1}.
    logic [2:0] sel_t [8] = '{3'b010, 3'b100, 3'b000, 3'b110, 3'b011, 3'b101, 3'b001, 3'b111};
    logic [5:0] tw_t  [8] = '{6'd8, 6'd1, 6'd10, 6'd3, 6'd8, 6'd1, 6'd10, 6'd3};

    r2sdf_seq_ctrl #(.N(3), .STAGE_REG(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .flush     (flush),
        .en        (en),
        .zero_in   (zero_in),
        .sel       (sel),
        .tw_addr   (tw_addr),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .frame_cnt (frame_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs and settle mid-cycle before checks.
    task automatic drive(input logic v, input logic s, input logic f, input logic r);
        rst      = r;
        in_valid = v;
        in_sof   = s;
        flush    = f;
        #4;
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dec(input string tag, input int idx);
        logic [2:0] i3;
        i3 = idx[2:0];
        chk({tag, "_sel"}, 32'(sel), 32'(sel_t[i3]));
        chk({tag, "_tw"}, 32'(tw_addr), 32'(tw_t[i3]));
    endtask

    initial begin
        int k;
        @(posedge clk);
        #1;
        // Reset behaviour
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_zero", 32'(zero_in), 32'd0);
        chk("rst_oval", 32'(out_valid), 32'd0);
        next_cyc();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("rst_en_gated", 32'(en), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        next_cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_fcnt", 32'(frame_cnt), 32'd0);
        chk("post_rst_oval", 32'(out_valid), 32'd0);
        next_cyc();

        // Two back-to-back frames, flush at sample 3 of frame 2, drain of 10 cycles
        for (int i = 0; i < 26; i++) begin
            drive(i < 16, (i < 16) && (i % 8 == 0), i == 11, 1'b0);
            chk("a_en", 32'(en), 32'd1);
            chk_dec("a", i);
            chk("a_oval", 32'(out_valid), 32'(i >= 10));
            chk("a_osof", 32'(out_sof), 32'((i == 10) || (i == 18)));
            chk("a_oeof", 32'(out_eof), 32'((i == 17) || (i == 25)));
            chk("a_ready", 32'(in_ready), 32'(i < 16));
            chk("a_zero", 32'(zero_in), 32'(i >= 16));
            if (i == 18) begin
                chk("a_fcnt1", 32'(frame_cnt), 32'd1);
            end else begin
                chk("a_err", 32'(err), 32'd0);
            end
            next_cyc();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("a_idle_ready", 32'(in_ready), 32'd1);
        chk("a_idle_zero", 32'(zero_in), 32'd0);
        chk("a_idle_en", 32'(en), 32'd0);
        chk("a_fcnt2", 32'(frame_cnt), 32'd2);
        next_cyc();
        // Stray sample without sof in IDLE is consumed, no advance
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("idle_stray_en", 32'(en), 32'd0);
        chk("idle_stray_ready", 32'(in_ready), 32'd1);
        next_cyc();

        // Stall of 3 cycles at sample 5; output shifts by 3 cycles
        for (int c = 0; c < 16; c++) begin
            logic v;
            v = !((c >= 5) && (c < 8));
            k = (c < 5) ? c : ((c < 8) ? 5 : c - 3);
            drive(v, c == 0, 1'b0, 1'b0);
            chk("s_en", 32'(en), 32'(v));
            chk_dec("s", k);
            chk("s_oval", 32'(out_valid), 32'(v && (k >= 10)));
            chk("s_osof", 32'(out_sof), 32'(c == 13));
            next_cyc();
        end

        // Resync: in_sof at adv 5
        for (int j = 0; j < 11; j++) begin
            drive(1'b1, j == 0, 1'b0, 1'b0);
            chk("r_err", 32'(err), 32'(j == 0));
            chk_dec("r", j);
            chk("r_oval", 32'(out_valid), 32'(j == 10));
            chk("r_osof", 32'(out_sof), 32'(j == 10));
            next_cyc();
        end

        // Flush requested at adv 3, reset on drain cycle 4
        for (int m = 0; m < 5; m++) begin
            drive(1'b1, 1'b0, m == 0, 1'b0);
            chk("f_ready", 32'(in_ready), 32'd1);
            chk_dec("f", 3 + m);
            next_cyc();
        end
        for (int f = 0; f < 4; f++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            chk("f_zero", 32'(zero_in), 32'd1);
            chk("f_ready0", 32'(in_ready), 32'd0);
            chk("f_en", 32'(en), 32'd1);
            next_cyc();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("mr_ready", 32'(in_ready), 32'd0);
        chk("mr_en", 32'(en), 32'd0);
        chk("mr_zero", 32'(zero_in), 32'd0);
        chk("mr_oval", 32'(out_valid), 32'd0);
        next_cyc();
        // Flush while IDLE must be ignored
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("mr_post_ready", 32'(in_ready), 32'd1);
        chk("mr_post_fcnt", 32'(frame_cnt), 32'd0);
        chk("mr_post_en", 32'(en), 32'd0);
        next_cyc();

        // Single frame, then flush at the stalled frame boundary
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, 1'b0, 1'b0);
            chk("b_en", 32'(en), 32'd1);
            chk("b_oval", 32'(out_valid), 32'd0);
            next_cyc();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("b_still_run", 32'(in_ready), 32'd1);
        chk("b_stall_en", 32'(en), 32'd0);
        next_cyc();
        for (int f = 0; f < 10; f++) begin
            drive(1'b0, 1'b0, f == 5, 1'b0);
            chk("b_zero", 32'(zero_in), 32'd1);
            chk("b_ready0", 32'(in_ready), 32'd0);
            chk("b_en", 32'(en), 32'd1);
            chk("b_oval", 32'(out_valid), 32'(f >= 2));
            chk("b_osof", 32'(out_sof), 32'(f == 2));
            chk("b_oeof", 32'(out_eof), 32'(f == 9));
            next_cyc();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("b_idle_ready", 32'(in_ready), 32'd1);
        chk("b_idle_zero", 32'(zero_in), 32'd0);
        chk("b_fcnt", 32'(frame_cnt), 32'd1);
        next_cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
